// File: rtl/cascade_counter.sv
// cascade_counter
//
// Chain of STAGES modulo counters, WIDTH bits each. Stage 0 moves by STEP per
// enabled cycle; every higher stage moves by one when all stages below it
// carry (up) or borrow (down). Used for grid scanning and display timing.
//
// Parameters
//   STAGES       number of cascaded stages (1..8)
//   WIDTH        bits per stage
//   MAX_VALUES   packed per-stage modulus (exclusive), stage i at [i*WIDTH +: WIDTH]
//   RESET_VALUES packed per-stage reset value
//   STEP         stage-0 increment/decrement, 1 <= STEP < modulus of stage 0
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset, highest priority
//   enable      advance the chain this cycle
//   up          1 = count up, 0 = count down
//   load        parallel load of load_value (wins over enable)
//   load_value  packed load data, same layout as count
//   count       registered stage values
//   carry       combinational per-stage carry/borrow-out in the current direction
//   done        registered one-cycle pulse after the whole chain wraps

module cascade_counter #(
    parameter int unsigned                STAGES       = 2,
    parameter int unsigned                WIDTH        = 8,
    parameter logic [STAGES*WIDTH-1:0]    MAX_VALUES   = {8'd48, 8'd64},
    parameter logic [STAGES*WIDTH-1:0]    RESET_VALUES = '0,
    parameter int unsigned                STEP         = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up,
    input  logic                      load,
    input  logic [STAGES*WIDTH-1:0]   load_value,
    output logic [STAGES*WIDTH-1:0]   count,
    output logic [STAGES-1:0]         carry,
    output logic                      done
);

    // Stage arithmetic is one bit wider than a stage so c + s never overflows
    // even when the modulus is close to 2^WIDTH.
    localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] OneExt  = {{WIDTH{1'b0}}, 1'b1};

    logic [STAGES*WIDTH-1:0] count_q, count_d;
    logic                    done_q, done_d;

    // Per-stage temporaries, recomputed for each stage inside the loop.
    logic [WIDTH:0]   c_ext, m_ext, s_ext;
    logic [WIDTH:0]   sum_up, nxt_up, nxt_dn;
    logic             wrap_up, wrap_dn;
    logic [WIDTH-1:0] stage_next;
    logic [WIDTH-1:0] ld_slice;
    logic             chain;

    always_comb begin
        count_d    = count_q;
        done_d     = 1'b0;
        carry      = '0;
        chain      = 1'b1;
        c_ext      = '0;
        m_ext      = '0;
        s_ext      = '0;
        sum_up     = '0;
        nxt_up     = '0;
        nxt_dn     = '0;
        wrap_up    = 1'b0;
        wrap_dn    = 1'b0;
        stage_next = '0;
        ld_slice   = '0;
        for (int i = 0; i < STAGES; i++) begin
            c_ext   = {1'b0, count_q[i*WIDTH +: WIDTH]};
            m_ext   = {1'b0, MAX_VALUES[i*WIDTH +: WIDTH]};
            s_ext   = (i == 0) ? StepExt : OneExt;

            sum_up  = c_ext + s_ext;
            wrap_up = (sum_up >= m_ext);
            wrap_dn = (c_ext < s_ext);
            nxt_up  = wrap_up ? (sum_up - m_ext) : sum_up;
            nxt_dn  = wrap_dn ? (c_ext + m_ext - s_ext) : (c_ext - s_ext);
            stage_next = WIDTH'(up ? nxt_up : nxt_dn);

            // Out-of-range load slices are folded back into range. This is the
            // defined behaviour for STEP == 1; for larger steps such a load is
            // illegal and gets the same folding rather than an undefined state.
            ld_slice = load_value[i*WIDTH +: WIDTH];
            if (load) begin
                count_d[i*WIDTH +: WIDTH] = ld_slice % MAX_VALUES[i*WIDTH +: WIDTH];
            end else if (enable && chain) begin
                // chain here is the AND of all lower-stage carries.
                count_d[i*WIDTH +: WIDTH] = stage_next;
            end

            chain    = chain & (up ? wrap_up : wrap_dn);
            carry[i] = chain;
        end
        // After the loop chain is the full-chain wrap flag.
        if (!load && enable) begin
            done_d = chain;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VALUES;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule
